// File: rtl/timer_cmd_pkg.sv
// Shared types and constants for the timer command transmitter.
// The frame is the fixed 1101 preamble followed by the 4-bit delay, MSB first.
package timer_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StSend,
        StWaitDone,
        StAckWait,
        StAck
    } tcmd_state_t;

    localparam logic [3:0]  PREAMBLE   = 4'b1101;
    localparam int unsigned FRAME_BITS = 8;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] delay);
        return {PREAMBLE, delay};
    endfunction

endpackage

// File: rtl/tcmd_shifter.sv
// MSB-first parallel-load shift register for one command frame.
// Tracks how many bits have left; last_o is high once the whole frame is out.
module tcmd_shifter
    import timer_cmd_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [FRAME_BITS-1:0] data_i,
    output logic                  msb_o,
    output logic                  last_o
);

    localparam int unsigned CntW = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            // Load together with shift means bit 7 leaves on the load edge.
            if (shift_i) begin
                sreg_d = {data_i[FRAME_BITS-2:0], 1'b0};
                cnt_d  = CntW'(1);
            end else begin
                sreg_d = data_i;
                cnt_d  = '0;
            end
        end else if (shift_i) begin
            sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
            if (cnt_q != CntW'(FRAME_BITS)) begin
                cnt_d = CntW'(cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign msb_o  = sreg_q[FRAME_BITS-1];
    assign last_o = (cnt_q == CntW'(FRAME_BITS));

endmodule

// File: rtl/timer_cmd_tx.sv
// Host-side driver for the serial start-pattern timer: sends preamble + delay on d,
// then waits for done, answers with ack, and aborts with an err pulse on watchdog expiry.
module timer_cmd_tx
    import timer_cmd_pkg::*;
#(
    parameter int unsigned IDLE_GAP       = 1,
    parameter int unsigned ACK_DELAY      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 17000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_delay,
    output logic       cmd_ready,
    output logic       d,
    input  logic       done,
    output logic       ack,
    output logic       busy,
    output logic       err
);

    localparam bit          WdEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned WdW  = WdEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdEn ? WdW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WdW-1:0] WdMax  = '1;
    localparam logic [3:0]     GapLast = 4'(IDLE_GAP);
    localparam logic [3:0]     AckLast = 4'(ACK_DELAY);

    tcmd_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           d_q, d_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;

    logic                  sh_load, sh_shift, sh_msb, sh_last;
    logic [FRAME_BITS-1:0] frame;

    assign frame = build_frame(cmd_delay);

    tcmd_shifter u_shifter (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (frame),
        .msb_o   (sh_msb),
        .last_o  (sh_last)
    );

    // d_d is the value d will carry in the cycle after this edge, so a bit is
    // emitted on every edge whose next state is StSend.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        d_d      = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    sh_load = 1'b1;
                    if (IDLE_GAP == 0) begin
                        sh_shift = 1'b1;
                        d_d      = frame[FRAME_BITS-1];
                        state_d  = StSend;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    sh_shift = 1'b1;
                    d_d      = sh_msb;
                    state_d  = StSend;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSend: begin
                if (sh_last) begin
                    wd_d    = '0;
                    state_d = StWaitDone;
                end else begin
                    sh_shift = 1'b1;
                    d_d      = sh_msb;
                end
            end
            StWaitDone: begin
                // done takes priority over a watchdog expiry on the same edge.
                if (done) begin
                    if (ACK_DELAY == 0) begin
                        ack_d   = 1'b1;
                        state_d = StAck;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = StAckWait;
                    end
                end else if (WdEn && (wd_q == WdLast)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (wd_q != WdMax) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StAckWait: begin
                if (cnt_q == AckLast) begin
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAck: begin
                if (done) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wd_q    <= '0;
            d_q     <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            d_q     <= d_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign d         = d_q;
    assign ack       = ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Bench for timer_cmd_tx: two configurations driven by directed and random transactions,
// each cycle checked against expectations computed from the frame/handshake timing rules.
module tb_timer_cmd_tx;

    localparam int G0 = 1;
    localparam int A0 = 0;
    localparam int T0 = 50;
    localparam int G1 = 0;
    localparam int A1 = 3;
    localparam int T1 = 0;

    logic       clk;
    logic       resetn;
    logic       cmd_valid [2];
    logic [3:0] cmd_delay [2];
    logic       done      [2];
    logic       cmd_ready [2];
    logic       tx_d      [2];
    logic       ack       [2];
    logic       busy      [2];
    logic       err       [2];

    int total = 0;
    int bad   = 0;

    timer_cmd_tx #(
        .IDLE_GAP       (G0),
        .ACK_DELAY      (A0),
        .TIMEOUT_CYCLES (T0)
    ) dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid[0]),
        .cmd_delay (cmd_delay[0]),
        .cmd_ready (cmd_ready[0]),
        .d         (tx_d[0]),
        .done      (done[0]),
        .ack       (ack[0]),
        .busy      (busy[0]),
        .err       (err[0])
    );

    timer_cmd_tx #(
        .IDLE_GAP       (G1),
        .ACK_DELAY      (A1),
        .TIMEOUT_CYCLES (T1)
    ) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid[1]),
        .cmd_delay (cmd_delay[1]),
        .cmd_ready (cmd_ready[1]),
        .d         (tx_d[1]),
        .done      (done[1]),
        .ack       (ack[1]),
        .busy      (busy[1]),
        .err       (err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input int k, input int c, input logic obs,
                       input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, k, c, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k);
        chk({tag, "_ready"}, k, 0, cmd_ready[k], 1'b1);
        chk({tag, "_busy"},  k, 0, busy[k],      1'b0);
        chk({tag, "_d"},     k, 0, tx_d[k],      1'b0);
        chk({tag, "_ack"},   k, 0, ack[k],       1'b0);
        chk({tag, "_err"},   k, 0, err[k],       1'b0);
    endtask

    // One transaction from the handshake to the first idle cycle. done is high in
    // cycles [e0,e1) (an early pulse that must be ignored) and [ds,dstop).
    task automatic txn(input int k, input logic [3:0] dly, input int e0, input int e1,
                       input int ds, input int dstop);
        int   g, a, t, w, s, m, endc, idx;
        bit   tmo;
        logic [7:0] bits;
        logic exp_d;
        g    = (k == 0) ? G0 : G1;
        a    = (k == 0) ? A0 : A1;
        t    = (k == 0) ? T0 : T1;
        w    = g + 9;
        bits = {4'b1101, dly};
        tmo  = (t > 0) && (ds > w + t - 1);
        s    = ds + a + 1;
        m    = (dstop > s) ? dstop : s;
        endc = tmo ? (w + t) : (m + 1);
        chk("pre_ready", k, 0, cmd_ready[k], 1'b1);
        cmd_valid[k] = 1'b1;
        cmd_delay[k] = dly;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            cmd_delay[k] = 4'($urandom);
            idx   = c - g - 1;
            exp_d = (idx >= 0 && idx < 8) ? bits[7 - idx] : 1'b0;
            chk("d",     k, c, tx_d[k],      exp_d);
            chk("busy",  k, c, busy[k],      c < endc);
            chk("ready", k, c, cmd_ready[k], c >= endc);
            chk("ack",   k, c, ack[k],       !tmo && c >= s && c <= m);
            chk("err",   k, c, err[k],       tmo && c == endc);
            done[k]      = (c >= e0 && c < e1) || (c >= ds && c < dstop);
            cmd_valid[k] = (c == endc) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_delay[k] = 4'h0;
            done[k]      = 1'b0;
        end
        #12;
        chk_idle("reset", 0);
        chk_idle("reset", 1);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(2);
        chk_idle("post_reset", 0);

        // Reference frame: delay 0101, done high cycles 20..22, ack 21..23, ready at 24.
        txn(0, 4'b0101, 0, 0, 20, 23);
        // Early done pulse during the frame must not be taken.
        txn(0, 4'b1110, 3, 6, 12, 14);
        // done and timeout on the same edge: done wins.
        txn(0, 4'b0011, 0, 0, G0 + 9 + T0 - 1, G0 + 9 + T0 + 1);
        // Watchdog expiry with done held low.
        txn(0, 4'b1001, 0, 0, 100000, 100000);
        idle_cycles(1);
        chk_idle("after_timeout", 0);

        // Ack delay 3 with no gap; watchdog disabled so a long wait never errors.
        txn(1, 4'b0110, 0, 0, 15, 17);
        txn(1, 4'b1010, 2, 4, 90, 91);

        // Back-to-back closed loop, delays 0, 7, 15.
        txn(1, 4'd0, 0, 0, 9 + 0 + 2, 9 + 0 + 4);
        txn(1, 4'd7, 0, 0, 9 + 7 + 2, 9 + 7 + 3);
        txn(1, 4'd15, 0, 0, 9 + 15 + 2, 9 + 15 + 5);

        // Asynchronous reset in the middle of the frame (d carries a 1 in cycle 5).
        cmd_valid[0] = 1'b1;
        cmd_delay[0] = 4'b1111;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cmd_valid[0] = 1'b0;
        end
        chk("mid_d", 0, 5, tx_d[0], 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk_idle("async_reset", 0);
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(1);
        txn(0, 4'b0100, 0, 0, 13, 15);

        for (int r = 0; r < 12; r++) begin
            int k, w, ds, e0;
            k  = r % 2;
            w  = ((k == 0) ? G0 : G1) + 9;
            e0 = $urandom_range(1, 5);
            ds = w + $urandom_range(0, 12);
            txn(k, 4'($urandom), e0, e0 + $urandom_range(0, 3), ds,
                ds + $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
